// File: rtl/env_vca_if.sv
// Sample/envelope handshake bundle for env_vca: strobed input sample with gain
// target in, strobed gain-scaled sample with clip flag and voice-busy status out.
interface env_vca_if #(
    parameter int BITSIZE = 16
);
    logic                       in_valid;
    logic signed [BITSIZE-1:0]  in_sample;
    logic        [15:0]         envelope;
    logic                       out_valid;
    logic signed [BITSIZE-1:0]  out_sample;
    logic                       clip;
    logic                       active;

    modport master (
        output in_valid, in_sample, envelope,
        input  out_valid, out_sample, clip, active
    );

    modport slave (
        input  in_valid, in_sample, envelope,
        output out_valid, out_sample, clip, active
    );
endinterface

// File: rtl/env_vca.sv
// Envelope-driven VCA: slew-limited Q1.14 gain applied to each accepted sample
// through a 3-stage pipeline (capture, multiply, round/saturate).
module env_vca #(
    parameter int BITSIZE   = 16,
    parameter int SLEW_STEP = 64
) (
    input  logic     clk,
    input  logic     reset,
    env_vca_if.slave bus
);
    localparam int PW = BITSIZE + 16;
    localparam logic        [16:0]   STEP = 17'(SLEW_STEP);
    localparam logic signed [PW-1:0] HALF = PW'(8192);
    localparam logic signed [PW-1:0] SMAX = {{17{1'b0}}, {(BITSIZE-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = {{17{1'b1}}, {(BITSIZE-1){1'b0}}};

    logic        [14:0]         g_q, g_d;
    logic                       s1_valid_q, s1_valid_d;
    logic signed [BITSIZE-1:0]  s1_sample_q, s1_sample_d;
    logic        [14:0]         s1_g_q, s1_g_d;
    logic                       s2_valid_q, s2_valid_d;
    logic signed [PW-1:0]       s2_prod_q, s2_prod_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [BITSIZE-1:0]  out_sample_q, out_sample_d;
    logic                       clip_q, clip_d;

    logic        [16:0]         g_w, t_w;
    logic signed [15:0]         gain_s;
    logic signed [PW-1:0]       rnd, shifted;
    logic                       unused_env_msb;

    assign unused_env_msb = bus.envelope[15];

    // 17-bit compare/add keeps g+STEP and t+STEP from wrapping past 0x7FFF
    always_comb begin
        g_w = {2'b00, g_q};
        t_w = {2'b00, bus.envelope[14:0]};
        g_d = g_q;
        if (bus.in_valid) begin
            if (SLEW_STEP == 0)          g_d = bus.envelope[14:0];
            else if (t_w > g_w + STEP)   g_d = 15'(g_w + STEP);
            else if (t_w + STEP < g_w)   g_d = 15'(g_w - STEP);
            else                         g_d = bus.envelope[14:0];
        end
    end

    // Stage 1 captures the freshly updated gain, not the previous one
    always_comb begin
        s1_valid_d  = bus.in_valid;
        s1_sample_d = bus.in_valid ? bus.in_sample : s1_sample_q;
        s1_g_d      = bus.in_valid ? g_d : s1_g_q;
    end

    always_comb begin
        gain_s     = signed'({1'b0, s1_g_q});
        s2_valid_d = s1_valid_q;
        s2_prod_d  = s1_valid_q ? PW'(s1_sample_q) * PW'(gain_s) : s2_prod_q;
    end

    always_comb begin
        rnd          = s2_prod_q + HALF;
        shifted      = rnd >>> 14;
        out_valid_d  = s2_valid_q;
        out_sample_d = out_sample_q;
        clip_d       = 1'b0;
        if (s2_valid_q) begin
            if (shifted > SMAX) begin
                out_sample_d = SMAX[BITSIZE-1:0];
                clip_d       = 1'b1;
            end else if (shifted < SMIN) begin
                out_sample_d = SMIN[BITSIZE-1:0];
                clip_d       = 1'b1;
            end else begin
                out_sample_d = shifted[BITSIZE-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            g_q          <= '0;
            s1_valid_q   <= 1'b0;
            s1_sample_q  <= '0;
            s1_g_q       <= '0;
            s2_valid_q   <= 1'b0;
            s2_prod_q    <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            clip_q       <= 1'b0;
        end else begin
            g_q          <= g_d;
            s1_valid_q   <= s1_valid_d;
            s1_sample_q  <= s1_sample_d;
            s1_g_q       <= s1_g_d;
            s2_valid_q   <= s2_valid_d;
            s2_prod_q    <= s2_prod_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            clip_q       <= clip_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_sample = out_sample_q;
    assign bus.clip       = clip_q;
    assign bus.active     = (g_q != '0) | s1_valid_q | s2_valid_q | out_valid_q;
endmodule
